// File: rtl/load_store_unit.sv
// Load/store unit: turns one RV32I load or store request into a single
// word-aligned memory handshake, with lane steering, sign/zero extension,
// alignment/legality checks and a bounded wait for the memory.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    // Wait-counter value on the last ACCESS cycle allowed before timing out
    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_load_data;
    logic        r_fault;
    logic [7:0]  r_cnt;
    logic        w_bad;
    logic        w_timeout;

    function automatic logic f_legal(input logic st, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010: return 1'b1;
            3'b100, 3'b101:         return !st;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic f_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] f_wstrb(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Pick the addressed lane out of the aligned word and extend it to 32 bits
    function automatic logic [31:0] f_load_ext(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] rd);
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        sb = rd[{a, 3'b000} +: 8];
        sh = a[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  return {{24{sb[7]}}, sb};
            3'b001:  return {{16{sh[15]}}, sh};
            3'b100:  return {24'h0, sb};
            3'b101:  return {16'h0, sh};
            default: return rd;
        endcase
    endfunction

    // Request screening happens on the live inputs so a bad request skips ACCESS
    assign w_bad     = !f_legal(is_store, funct3) || f_misaligned(funct3, addr[1:0]);
    assign w_timeout = (r_cnt == LP_LAST);

    assign load_data = r_load_data;
    assign fault     = r_fault;
    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next  = r_state;
        busy    = 1'b0;
        done    = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = w_bad ? DONE : ACCESS;
            end
            ACCESS: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = r_is_store;
                if (mem_ready || w_timeout) w_next = DONE;
            end
            DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request latch, wait counter and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_store  <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_wstrb     <= 4'b0000;
            r_load_data <= 32'h0;
            r_fault     <= 1'b0;
            r_cnt       <= 8'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_is_store <= is_store;
                        r_funct3   <= funct3;
                        r_addr     <= addr;
                        r_cnt      <= 8'h0;
                        r_wdata    <= is_store ? f_wdata(funct3, store_data) : 32'h0;
                        r_wstrb    <= (is_store && !w_bad) ? f_wstrb(funct3, addr[1:0]) : 4'b0000;
                        if (w_bad) begin
                            r_fault     <= 1'b1;
                            r_load_data <= 32'h0;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        r_fault     <= 1'b0;
                        r_load_data <= r_is_store ? 32'h0
                                                  : f_load_ext(r_funct3, r_addr[1:0], mem_rdata);
                    end else begin
                        r_cnt <= r_cnt + 8'h1;
                        if (w_timeout) begin
                            r_fault     <= 1'b1;
                            r_load_data <= 32'h0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver issues directed requests and
// queues expected memory transactions and completions; one monitor process
// plays the memory and checks every handshake and done pulse.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        busy, done, fault, mem_req, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        int          len;
    } mem_t;

    typedef struct {
        logic [31:0] ld;
        logic        flt;
        int          t_start;
        int          lat;
    } exp_t;

    mem_t mem_q[$];
    exp_t exp_q[$];

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   req_cnt = 0;
    bit   have_cur = 0;
    mem_t cur;
    exp_t e;
    bit   chk_idle = 0;
    bit   idle_ready = 0;

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
        .addr(addr), .store_data(store_data), .busy(busy), .done(done),
        .load_data(load_data), .fault(fault), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model and scoreboard monitor
    always @(negedge clk) begin
        if (chk_idle) begin
            chk("idle_busy", {31'h0, busy}, 32'h0);
            chk("idle_done", {31'h0, done}, 32'h0);
            chk("idle_fault", {31'h0, fault}, 32'h0);
            chk("idle_mem_req", {31'h0, mem_req}, 32'h0);
            chk("idle_mem_we", {31'h0, mem_we}, 32'h0);
            chk("idle_load_data", load_data, 32'h0);
            chk("idle_mem_addr", mem_addr, 32'h0);
            chk("idle_mem_wdata", mem_wdata, 32'h0);
            chk("idle_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        end
        if (mem_req) begin
            if (req_cnt == 0) begin
                total++;
                if (mem_q.size() == 0) begin
                    bad++;
                    have_cur = 0;
                    $display("FAIL unexpected_mem_req got=1 exp=0 addr=%h (cycle %0d)", mem_addr, cyc);
                end else begin
                    cur = mem_q.pop_front();
                    have_cur = 1;
                    chk("mem_addr", mem_addr, cur.addr);
                    chk("mem_we", {31'h0, mem_we}, {31'h0, cur.we});
                    chk("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, cur.wstrb});
                    if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
                end
            end else if (have_cur) begin
                chk("mem_addr_hold", mem_addr, cur.addr);
            end
            if (have_cur) begin
                mem_ready = (req_cnt == cur.delay);
                mem_rdata = cur.rdata;
            end else begin
                mem_ready = 1'b1;
            end
            req_cnt++;
        end else begin
            if (req_cnt != 0 && have_cur) chk("mem_req_len", req_cnt, cur.len);
            req_cnt  = 0;
            have_cur = 0;
            mem_ready = idle_ready;
            mem_rdata = 32'hA5A5_A5A5;
        end
        if (done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done got=1 exp=0 (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("done_cycle", cyc, e.t_start + e.lat);
                chk("load_data", load_data, e.ld);
                chk("fault", {31'h0, fault}, {31'h0, e.flt});
            end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].t_start + exp_q[0].lat) begin
            total++;
            bad++;
            $display("FAIL missing_done got=0 exp=1 (cycle %0d)", cyc);
            void'(exp_q.pop_front());
        end
    end

    // Issue one request; len=0 means no memory access is expected
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] m_addr,
                         input logic [3:0] m_wstrb, input logic [31:0] m_wdata,
                         input logic [31:0] rd, input int delay, input int len,
                         input logic [31:0] x_ld, input logic x_flt, input int lat);
        mem_t m;
        exp_t x;
        @(posedge clk); #1;
        if (len > 0) begin
            m.addr = m_addr; m.we = st; m.wstrb = m_wstrb; m.wdata = m_wdata;
            m.rdata = rd; m.delay = delay; m.len = len;
            mem_q.push_back(m);
        end
        x.ld = x_ld; x.flt = x_flt; x.t_start = cyc; x.lat = lat;
        exp_q.push_back(x);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_idle = 1'b1;
        @(posedge clk); #1;
        chk_idle = 1'b0;

        // Loads: word, byte/half with sign and zero extension
        issue(0, 3'b010, 32'h100, 32'h0, 32'h100, 4'b0000, 32'h0, 32'hDEADBEEF, 1, 2, 32'hDEADBEEF, 0, 3);
        issue(0, 3'b000, 32'h103, 32'h0, 32'h100, 4'b0000, 32'h0, 32'h80FF0000, 0, 1, 32'hFFFFFF80, 0, 2);
        issue(0, 3'b100, 32'h103, 32'h0, 32'h100, 4'b0000, 32'h0, 32'h80FF0000, 0, 1, 32'h00000080, 0, 2);
        issue(0, 3'b101, 32'h102, 32'h0, 32'h100, 4'b0000, 32'h0, 32'h80FF0000, 0, 1, 32'h000080FF, 0, 2);
        issue(0, 3'b001, 32'h102, 32'h0, 32'h100, 4'b0000, 32'h0, 32'h80FF0000, 2, 3, 32'hFFFF80FF, 0, 4);
        issue(0, 3'b000, 32'h201, 32'h0, 32'h200, 4'b0000, 32'h0, 32'h1234F67F, 0, 1, 32'hFFFFFFF6, 0, 2);
        issue(0, 3'b001, 32'h200, 32'h0, 32'h200, 4'b0000, 32'h0, 32'h1234567F, 0, 1, 32'h0000567F, 0, 2);

        // Stores: strobes and lane replication, load_data reads 0
        issue(1, 3'b000, 32'h21, 32'h12345678, 32'h20, 4'b0010, 32'h78787878, 32'h0, 0, 1, 32'h0, 0, 2);
        issue(1, 3'b001, 32'h22, 32'h12345678, 32'h20, 4'b1100, 32'h56785678, 32'h0, 0, 1, 32'h0, 0, 2);
        issue(1, 3'b010, 32'h30, 32'hCAFEF00D, 32'h30, 4'b1111, 32'hCAFEF00D, 32'h0, 1, 2, 32'h0, 0, 3);

        // Faulted requests never reach memory and finish in one cycle
        issue(0, 3'b010, 32'h102, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 0, 0, 32'h0, 1, 1);
        issue(1, 3'b001, 32'h101, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 0, 0, 32'h0, 1, 1);
        issue(0, 3'b011, 32'h100, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 0, 0, 32'h0, 1, 1);
        issue(1, 3'b100, 32'h100, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 0, 0, 32'h0, 1, 1);
        issue(0, 3'b010, 32'h101, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 0, 0, 32'h0, 1, 1);

        // mem_ready toggling high while idle must not disturb anything
        idle_ready = 1'b1;
        issue(0, 3'b010, 32'h40, 32'h0, 32'h40, 4'b0000, 32'h0, 32'h0BADF00D, 3, 4, 32'h0BADF00D, 0, 5);

        // Memory never answers: 16 request cycles then a faulted done
        idle_ready = 1'b0;
        issue(0, 3'b010, 32'h200, 32'h0, 32'h200, 4'b0000, 32'h0, 32'h0, -1, 16, 32'h0, 1, 17);
        issue(0, 3'b101, 32'h206, 32'h0, 32'h204, 4'b0000, 32'h0, 32'hFEDC0123, 0, 1, 32'h0000FEDC, 0, 2);

        // Reset in the third ACCESS cycle; a second start while busy is ignored
        @(posedge clk); #1;
        cur.addr = 32'h0;
        begin
            mem_t m;
            m.addr = 32'h100; m.we = 1'b0; m.wstrb = 4'b0000; m.wdata = 32'h0;
            m.rdata = 32'h0; m.delay = -1; m.len = 3;
            mem_q.push_back(m);
        end
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h100;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; addr = 32'h300; funct3 = 3'b000;
        @(posedge clk); #1;
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_idle = 1'b1;
        @(posedge clk); #1;
        chk_idle = 1'b0;
        repeat (5) @(posedge clk);

        // Unit still works after the abort
        issue(1, 3'b000, 32'h13, 32'h000000AB, 32'h10, 4'b1000, 32'hABABABAB, 32'h0, 0, 1, 32'h0, 0, 2);

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter: TIMEOUT, 16, max cycles ACCESS waits for mem_ready before faulting (1..255).
REQ-002 The block SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port: rst  input  1  synchronous active-high reset.
REQ-004 The block SHALL have port: start  input  1  one-cycle request pulse, sampled only in IDLE.
REQ-005 The block SHALL have port: is_store  input  1  1 = store, 0 = load.
REQ-006 The block SHALL have port: funct3  input  3  RV32I width/sign code.
REQ-007 The block SHALL have port: addr  input  32  effective address (FunctionUnit Result, FS=ADD).
REQ-008 The block SHALL have port: store_data  input  32  rs2 value.
REQ-009 The block SHALL have port: busy  output  1  high in every state except IDLE.
REQ-010 The block SHALL have port: done  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have port: load_data  output  32  extended load result, valid with done.
REQ-012 The block SHALL have port: fault  output  1  valid with done; misaligned, illegal funct3 or timeout.
REQ-013 The block SHALL have ports: mem_req out 1; mem_we out 1; mem_addr out 32; mem_wdata out 32; mem_wstrb out 4; mem_rdata in 32; mem_ready in 1.

Function
REQ-014 The block SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-015 IDLE + start SHALL latch is_store, funct3, addr, store_data; go to DONE with fault=1 if request is illegal or misaligned, else ACCESS.
REQ-016 start SHALL be ignored whenever busy=1.
REQ-017 Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores: 000 SB, 001 SH, 010 SW; all other codes illegal.
REQ-018 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=00; byte never misaligned.
REQ-019 Faulted requests SHALL never assert mem_req.
REQ-020 In ACCESS: mem_req=1, mem_addr={addr[31:2],2'b00}, mem_we=is_store; all memory outputs stable until mem_ready sampled high.
REQ-021 mem_ready high in ACCESS SHALL capture mem_rdata and move to DONE; mem_req low in the following cycle.
REQ-022 Store strobes: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111; loads 4'b0000.
REQ-023 Store data: SB byte replicated in 4 lanes; SH halfword replicated in 2 lanes; SW unchanged.
REQ-024 Load data: lane chosen by addr[1:0] (byte) or addr[1] (half); LB/LH sign-extend, LBU/LHU zero-extend; stores and faults give load_data=0.
REQ-025 A wait counter SHALL clear on ACCESS entry; after TIMEOUT cycles in ACCESS without mem_ready -> DONE with fault=1.
REQ-026 DONE SHALL assert done for exactly one cycle, then return to IDLE; load_data/fault held until next done.
REQ-027 Latency: start in cycle n, mem_req from n+1; mem_ready in cycle m gives done in m+1 (minimum 2 cycles); faulted request gives done in n+1.
REQ-028 mem_ready outside ACCESS SHALL be ignored.

Reset
REQ-029 rst SHALL force IDLE; busy, done, fault, mem_req, mem_we = 0; load_data, mem_addr, mem_wdata = 0; mem_wstrb = 0; wait counter = 0.
REQ-030 rst during ACCESS SHALL drop mem_req on the next edge with no done pulse; rst has priority over start.

Verification
REQ-031 LW addr=0x100, mem_rdata=0xDEADBEEF, ready 1 cycle after req -> mem_addr=0x100, wstrb=0000, done at start+3, load_data=0xDEADBEEF, fault=0.
REQ-032 LB addr=0x103, rdata=0x80FF_0000 -> load_data=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x102 -> 0x000080FF.
REQ-033 SB addr=0x21, store_data=0x12345678 -> mem_we=1, wstrb=0010, wdata=0x78787878, mem_addr=0x20; SH addr=0x22 -> wstrb=1100, wdata=0x56785678.
REQ-034 LW addr=0x102; SH addr=0x101; funct3=011 -> no mem_req, done at start+1, fault=1.
REQ-035 TIMEOUT=16, mem_ready held 0 -> mem_req high 16 cycles, then done with fault=1, mem_req=0.
REQ-036 rst asserted in 3rd ACCESS cycle -> mem_req=0 and busy=0 next cycle, no done; second start during busy ignored.
